tcm_conf_ctrl: RTL and testbench
================================

# tcm_conf_ctrl

Command-driven configuration controller for the TuMan32 core's instruction and data TCMs. It accepts host commands over a valid/ready channel and sequences them onto the TCM configuration ports (`conf_*_itcm`, `conf_*_dtcm`). It owns the core-hold line (`conf_sel_dtcm`), which holds the core in reset while program or data images are loaded or read back. Every command returns exactly one response, and memory access is refused unless the core is held and settled.

## Interface
Parameters:
- `SETTLE_CYC`, default 2: cycles between hold assertion and the first permitted memory access (1..255).
- `RD_LAT`, default 1: TCM configuration read latency, in cycles from the `rden` pulse to valid `rdata` (1..7).
- `HOLD_ON_RESET`, default 1: reset value of `conf_sel_dtcm_o`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: the single clock.
  - `reset` in 1: synchronous, active-high.
- Command channel:
  - `cmd_valid_i` in 1: command offered.
  - `cmd_ready_o` out 1: controller can accept a command.
  - `cmd_op_i` in 3: 000 WR_I, 001 WR_D, 010 RD_I, 011 RD_D, 100 HOLD, 101 RELEASE; 110 and 111 are illegal.
  - `cmd_addr_i` in 32: TCM word address, forwarded unchanged.
  - `cmd_wdata_i` in 32: write data.
- Response channel:
  - `rsp_valid_o` out 1: response available.
  - `rsp_ready_i` in 1: host accepts the response.
  - `rsp_data_o` out 32: read data; 0 for non-read commands.
  - `rsp_err_o` out 1: command refused.
- ITCM configuration port:
  - `conf_rden_itcm_o`, `conf_wren_itcm_o` out 1.
  - `conf_addr_itcm_o`, `conf_wdata_itcm_o` out 32.
  - `conf_rdata_itcm_i` in 32.
- DTCM configuration port:
  - `conf_rden_dtcm_o`, `conf_wren_dtcm_o` out 1.
  - `conf_addr_dtcm_o`, `conf_wdata_dtcm_o` out 32.
  - `conf_rdata_dtcm_i` in 32.
- Core hold:
  - `conf_sel_dtcm_o` out 1: 1 holds the core in reset.
  - `held_o` out 1: hold is asserted and settling is complete.

## Operation
- States: IDLE, SETTLE, WRITE, READ, RESP. Reset enters IDLE.
- Handshake:
  - `cmd_ready_o` = (state==IDLE).
  - A command is accepted when `cmd_valid_i & cmd_ready_o`; op, addr and wdata are registered on acceptance.
- IDLE, on acceptance:
  - WR_I/WR_D with `held_o`=1 → WRITE.
  - RD_I/RD_D with `held_o`=1 → READ, with the latency counter loaded to `RD_LAT`.
  - Any memory op with `held_o`=0 → RESP with err=1. No strobe is issued.
  - HOLD → `conf_sel_dtcm_o`=1, settle counter loaded to `SETTLE_CYC`, → SETTLE. If the core is already held, the counter is still reloaded.
  - RELEASE → `conf_sel_dtcm_o`=0, `held_o`=0, → RESP with err=0.
  - Illegal op → RESP with err=1.
- SETTLE: the counter decrements each cycle. At 0, `held_o`=1 and the state moves to RESP with err=0.
- WRITE:
  - One-cycle `wren` pulse on the selected TCM only.
  - addr and wdata are driven from the registers during the pulse.
  - → RESP with data=0, err=0.
- READ:
  - One-cycle `rden` pulse with addr.
  - The counter then decrements once per cycle.
  - On the cycle the count reaches 0, the selected `rdata` is captured into `rsp_data_o`. → RESP with err=0.
- RESP:
  - `rsp_valid_o`=1; data and err are held stable until `rsp_ready_i`.
  - → IDLE on the handshake cycle.
- Only one TCM strobe is ever active, and never both `rden` and `wren`.
- `conf_addr_*`/`conf_wdata_*` are zero whenever their strobes are low.
- `conf_sel_dtcm_o` changes only on HOLD/RELEASE acceptance or on reset.

## Timing
- Reset values:
  - `cmd_ready_o`=1.
  - `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0.
  - All `conf_*` strobes, addrs and wdata = 0.
  - `conf_sel_dtcm_o`=`HOLD_ON_RESET`.
  - `held_o`=0. Even when `HOLD_ON_RESET`=1, a HOLD command is required to settle.
- Write: accept at cycle T, `wren` at T+1, `rsp_valid_o` at T+2.
- Read: accept at T, `rden` at T+1, rdata sampled at T+1+`RD_LAT`, `rsp_valid_o` at T+2+`RD_LAT`.
- HOLD: accept at T, `conf_sel_dtcm_o`=1 from T+1, `held_o` and `rsp_valid_o` at T+1+`SETTLE_CYC`.
- RELEASE or any refused command: `rsp_valid_o` at T+1. RELEASE also has `conf_sel_dtcm_o`=0 from T+1.
- Back-to-back: the next command can be accepted in the cycle after the response handshake. Peak rate is one write per 3 cycles.
- Response stall: `rsp_ready_i`=0 holds RESP indefinitely; `cmd_ready_o` stays 0 throughout.
- Reset mid-operation: all state is discarded, in-flight strobes drop the next cycle, and any pending response is lost.

## Structure
- Package `tcm_conf_pkg` holds:
  - Op codes: `OP_WR_I`…`OP_RELEASE`.
  - State enum: `ST_IDLE`…`ST_RESP`.
  - Widths: `ADDR_W`=32, `DATA_W`=32.
- A single flat module; no sub-module is needed. The counters for settle and latency share one 8-bit register.

## Test plan
1. Reset with `HOLD_ON_RESET`=1 → `conf_sel_dtcm_o`=1, `held_o`=0. Then RD_D addr 0x10 → err=1, no `rden` strobe observed.
2. HOLD → `held_o` rises exactly 3 cycles after acceptance (`SETTLE_CYC`=2). Then WR_I addr 0x4 data 0xDEADBEEF → one `conf_wren_itcm_o` pulse with addr 0x4 and data 0xDEADBEEF, DTCM strobes silent, response err=0 data=0.
3. With the core held, RD_I addr 0x4 against an ITCM model (`RD_LAT`=1) → `rsp_data_o`=0xDEADBEEF at T+3. Repeat with `RD_LAT`=3 → response at T+5.
4. Hold `rsp_ready_i` low for 10 cycles after a write → `rsp_valid_o`, data and err stable and `cmd_ready_o`=0 for all 10 cycles. The next command is accepted the cycle after the handshake.
5. RELEASE → `conf_sel_dtcm_o`=0 at T+1. A subsequent WR_D → err=1 with no strobe. Op 110 → err=1.
6. Assert `reset` for one cycle during READ wait (`RD_LAT`=3) → no response is issued, and all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/tcm_conf_pkg.sv
// Shared op codes, FSM states and widths for the TCM configuration controller.
// Helper functions decode the memory-op class from the raw 3-bit op field.
package tcm_conf_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_WR_I    = 3'b000,
    OP_WR_D    = 3'b001,
    OP_RD_I    = 3'b010,
    OP_RD_D    = 3'b011,
    OP_HOLD    = 3'b100,
    OP_RELEASE = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_e;

  // Memory ops occupy codes 0..3; bit 0 selects the DTCM, bit 1 selects read.
  function automatic logic op_is_dtcm(input logic [2:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_read(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/tcm_conf_ctrl.sv
// Sequences host commands onto the ITCM/DTCM config ports and owns the core-hold line.
// Write resp at T+2, read at T+2+RD_LAT, hold at T+1+SETTLE_CYC; one command in flight, RESP stalls on rsp_ready_i.
module tcm_conf_ctrl
  import tcm_conf_pkg::*;
#(
  parameter int SETTLE_CYC    = 2,
  parameter int RD_LAT        = 1,
  parameter bit HOLD_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,

  output logic              conf_rden_itcm_o,
  output logic              conf_wren_itcm_o,
  output logic [ADDR_W-1:0] conf_addr_itcm_o,
  output logic [DATA_W-1:0] conf_wdata_itcm_o,
  input  logic [DATA_W-1:0] conf_rdata_itcm_i,

  output logic              conf_rden_dtcm_o,
  output logic              conf_wren_dtcm_o,
  output logic [ADDR_W-1:0] conf_addr_dtcm_o,
  output logic [DATA_W-1:0] conf_wdata_dtcm_o,
  input  logic [DATA_W-1:0] conf_rdata_dtcm_i,

  output logic              conf_sel_dtcm_o,
  output logic              held_o
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              held_q, held_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic wr_stb, rd_stb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      sel_q      <= HOLD_ON_RESET;
      held_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      held_q     <= held_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    held_d     = held_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d       = cmd_op_i;
          addr_d     = cmd_addr_i;
          wdata_d    = cmd_wdata_i;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (cmd_op_i)
            OP_WR_I, OP_WR_D: begin
              if (held_q) begin
                state_d = ST_WRITE;
              end else begin
                rsp_err_d = 1'b1;
                state_d   = ST_RESP;
              end
            end
            OP_RD_I, OP_RD_D: begin
              if (held_q) begin
                cnt_d   = 8'(RD_LAT);
                state_d = ST_READ;
              end else begin
                rsp_err_d = 1'b1;
                state_d   = ST_RESP;
              end
            end
            OP_HOLD: begin
              sel_d   = 1'b1;
              cnt_d   = 8'(SETTLE_CYC);
              state_d = ST_SETTLE;
            end
            OP_RELEASE: begin
              sel_d   = 1'b0;
              held_d  = 1'b0;
              state_d = ST_RESP;
            end
            default: begin
              rsp_err_d = 1'b1;
              state_d   = ST_RESP;
            end
          endcase
        end
      end

      // Counter reaching zero coincides with the response, so exit on the 1->0 step.
      ST_SETTLE: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          held_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_WRITE: begin
        state_d = ST_RESP;
      end

      ST_READ: begin
        if (cnt_q == 8'd0) begin
          rsp_data_d = op_is_dtcm(op_q) ? conf_rdata_dtcm_i : conf_rdata_itcm_i;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The rden pulse is the first READ cycle, while the counter still holds its load value.
  assign wr_stb = (state_q == ST_WRITE);
  assign rd_stb = (state_q == ST_READ) && (cnt_q == 8'(RD_LAT));

  assign conf_wren_itcm_o  = wr_stb && !op_is_dtcm(op_q);
  assign conf_wren_dtcm_o  = wr_stb &&  op_is_dtcm(op_q);
  assign conf_rden_itcm_o  = rd_stb && !op_is_dtcm(op_q);
  assign conf_rden_dtcm_o  = rd_stb &&  op_is_dtcm(op_q);

  assign conf_addr_itcm_o  = (conf_wren_itcm_o || conf_rden_itcm_o) ? addr_q : '0;
  assign conf_addr_dtcm_o  = (conf_wren_dtcm_o || conf_rden_dtcm_o) ? addr_q : '0;
  assign conf_wdata_itcm_o = conf_wren_itcm_o ? wdata_q : '0;
  assign conf_wdata_dtcm_o = conf_wren_dtcm_o ? wdata_q : '0;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = rsp_valid_o ? rsp_data_q : '0;
  assign rsp_err_o   = rsp_valid_o ? rsp_err_q : 1'b0;

  assign conf_sel_dtcm_o = sel_q;
  assign held_o          = held_q;

endmodule

// File: tb/tb_tcm_conf_ctrl.sv
// Bench for tcm_conf_ctrl: two instances (RD_LAT 1 and 3) driven by directed and random commands.
// Each response is predicted from a transaction-level model of hold state and TCM contents.
module tb_tcm_conf_ctrl;
  import tcm_conf_pkg::*;

  localparam int SETTLE = 2;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  logic clk = 1'b0;
  logic reset;
  int   cyc;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [2:0]  cmd_op    [2];
  logic [31:0] cmd_addr  [2];
  logic [31:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        rden_i [2], wren_i [2], rden_d [2], wren_d [2];
  logic [31:0] addr_i [2], wdata_i [2], rdata_i [2];
  logic [31:0] addr_d [2], wdata_d [2], rdata_d [2];
  logic        sel  [2];
  logic        held [2];

  tcm_conf_ctrl #(.SETTLE_CYC(SETTLE), .RD_LAT(1), .HOLD_ON_RESET(1'b1)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]), .cmd_op_i(cmd_op[0]),
    .cmd_addr_i(cmd_addr[0]), .cmd_wdata_i(cmd_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]), .rsp_err_o(rsp_err[0]),
    .conf_rden_itcm_o(rden_i[0]), .conf_wren_itcm_o(wren_i[0]), .conf_addr_itcm_o(addr_i[0]),
    .conf_wdata_itcm_o(wdata_i[0]), .conf_rdata_itcm_i(rdata_i[0]),
    .conf_rden_dtcm_o(rden_d[0]), .conf_wren_dtcm_o(wren_d[0]), .conf_addr_dtcm_o(addr_d[0]),
    .conf_wdata_dtcm_o(wdata_d[0]), .conf_rdata_dtcm_i(rdata_d[0]),
    .conf_sel_dtcm_o(sel[0]), .held_o(held[0])
  );

  tcm_conf_ctrl #(.SETTLE_CYC(SETTLE), .RD_LAT(3), .HOLD_ON_RESET(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]), .cmd_op_i(cmd_op[1]),
    .cmd_addr_i(cmd_addr[1]), .cmd_wdata_i(cmd_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]), .rsp_err_o(rsp_err[1]),
    .conf_rden_itcm_o(rden_i[1]), .conf_wren_itcm_o(wren_i[1]), .conf_addr_itcm_o(addr_i[1]),
    .conf_wdata_itcm_o(wdata_i[1]), .conf_rdata_itcm_i(rdata_i[1]),
    .conf_rden_dtcm_o(rden_d[1]), .conf_wren_dtcm_o(wren_d[1]), .conf_addr_dtcm_o(addr_d[1]),
    .conf_wdata_dtcm_o(wdata_d[1]), .conf_rdata_dtcm_i(rdata_d[1]),
    .conf_sel_dtcm_o(sel[1]), .held_o(held[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical TCM models: written by DUT strobes, read data valid lat_of(k) cycles after rden.
  logic [31:0]     imem [2][16];
  logic [31:0]     dmem [2][16];
  logic [7:0]      pvi [2], pvd [2];
  logic [7:0][3:0] pai [2], pad [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int a = 0; a < 16; a++) begin
          imem[k][a] <= '0;
          dmem[k][a] <= '0;
        end
        pvi[k] <= '0;
        pvd[k] <= '0;
      end else begin
        if (wren_i[k]) imem[k][addr_i[k][5:2]] <= wdata_i[k];
        if (wren_d[k]) dmem[k][addr_d[k][5:2]] <= wdata_d[k];
        pvi[k] <= {pvi[k][6:0], rden_i[k]};
        pvd[k] <= {pvd[k][6:0], rden_d[k]};
      end
      pai[k] <= {pai[k][6:0], addr_i[k][5:2]};
      pad[k] <= {pad[k][6:0], addr_d[k][5:2]};
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rdata_i[k] = pvi[k][lat_of(k)-1] ? imem[k][pai[k][lat_of(k)-1]] : (32'hA5A5_5A5A ^ 32'(cyc));
      rdata_d[k] = pvd[k][lat_of(k)-1] ? dmem[k][pad[k][lat_of(k)-1]] : (32'h5A5A_A5A5 ^ 32'(cyc));
    end
  end

  // Transaction-level reference: hold state and expected memory contents per instance.
  logic        m_sel  [2];
  logic        m_held [2];
  logic [31:0] sb_i [2][16];
  logic [31:0] sb_d [2][16];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sel[k]  = 1'b1;
      m_held[k] = 1'b0;
      for (int a = 0; a < 16; a++) begin
        sb_i[k][a] = '0;
        sb_d[k][a] = '0;
      end
    end
  endtask

  task automatic check_reset_outs(input int k);
    check_eq("rst_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    check_eq("rst_rsp_data", rsp_data[k], 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
    check_eq("rst_strobes", 32'({wren_d[k], rden_d[k], wren_i[k], rden_i[k]}), 32'd0);
    check_eq("rst_conf_bus", addr_i[k] | wdata_i[k] | addr_d[k] | wdata_d[k], 32'd0);
    check_eq("rst_sel", 32'(sel[k]), 32'd1);
    check_eq("rst_held", 32'(held[k]), 32'd0);
  endtask

  // Called just after a negedge; returns just after the negedge following the response handshake.
  task automatic do_cmd(input int idx, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall);
    int          exp_lat, got_lat, n_stb, stb_k, bad_zero, bad_sel, bad_rdy;
    logic        exp_err, exp_sel, exp_held, wr, dt;
    logic [31:0] exp_data, stb_addr, stb_wdata, hold_data;
    logic        hold_err;
    logic [3:0]  exp_kind, stb_kind, kind;

    wr = (op[2:1] == 2'b00);
    dt = op[0];
    exp_sel = m_sel[idx];  exp_held = m_held[idx];
    exp_err = 1'b0;  exp_data = '0;  exp_kind = '0;  exp_lat = 1;
    if (op > 3'd5) begin
      exp_err = 1'b1;
    end else if (op == OP_HOLD) begin
      exp_lat = 1 + SETTLE;  exp_sel = 1'b1;  exp_held = 1'b1;
    end else if (op == OP_RELEASE) begin
      exp_sel = 1'b0;  exp_held = 1'b0;
    end else if (!m_held[idx]) begin
      exp_err = 1'b1;
    end else if (wr) begin
      exp_lat = 2;  exp_kind = dt ? 4'b1000 : 4'b0010;
    end else begin
      exp_lat  = 2 + lat_of(idx);
      exp_kind = dt ? 4'b0100 : 4'b0001;
      exp_data = dt ? sb_d[idx][addr[5:2]] : sb_i[idx][addr[5:2]];
    end

    check_eq("cmd_ready_idle", 32'(cmd_ready[idx]), 32'd1);
    check_eq("sel_before", 32'(sel[idx]), 32'(m_sel[idx]));
    check_eq("held_idle", 32'(held[idx]), 32'(m_held[idx]));
    cmd_valid[idx] = 1'b1;  cmd_op[idx] = op;  cmd_addr[idx] = addr;  cmd_wdata[idx] = wdata;
    rsp_ready[idx] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[idx] = 1'b0;
    cmd_op[idx] = 3'($urandom);  cmd_addr[idx] = $urandom;  cmd_wdata[idx] = $urandom;

    got_lat = -1;  n_stb = 0;  stb_k = 0;  bad_zero = 0;  bad_sel = 0;  bad_rdy = 0;
    stb_kind = '0;  stb_addr = '0;  stb_wdata = '0;
    for (int k = 1; k <= 40; k++) begin
      kind = {wren_d[idx], rden_d[idx], wren_i[idx], rden_i[idx]};
      if (kind != 4'b0) begin
        n_stb    += $countones(kind);
        stb_k     = k;
        stb_kind  = kind;
        stb_addr  = (kind[1:0] != 2'b0) ? addr_i[idx] : addr_d[idx];
        stb_wdata = (kind[1:0] != 2'b0) ? wdata_i[idx] : wdata_d[idx];
      end
      if (!(rden_i[idx] | wren_i[idx]) && ((addr_i[idx] | wdata_i[idx]) != 0)) bad_zero++;
      if (!(rden_d[idx] | wren_d[idx]) && ((addr_d[idx] | wdata_d[idx]) != 0)) bad_zero++;
      if (sel[idx] !== exp_sel) bad_sel++;
      if (cmd_ready[idx] !== 1'b0) bad_rdy++;
      if (rsp_valid[idx] === 1'b1) begin
        got_lat = k;
        break;
      end
      @(negedge clk);
    end

    check_eq("rsp_latency", 32'(got_lat), 32'(exp_lat));
    check_eq("rsp_err", 32'(rsp_err[idx]), 32'(exp_err));
    check_eq("rsp_data", rsp_data[idx], exp_data);
    check_eq("held_at_rsp", 32'(held[idx]), 32'(exp_held));
    check_eq("strobe_count", 32'(n_stb), (exp_kind != 4'b0) ? 32'd1 : 32'd0);
    check_eq("strobe_kind", 32'(stb_kind), 32'(exp_kind));
    if (exp_kind != 4'b0) begin
      check_eq("strobe_cycle", 32'(stb_k), 32'd1);
      check_eq("strobe_addr", stb_addr, addr);
      check_eq("strobe_wdata", stb_wdata, wr ? wdata : 32'd0);
    end
    check_eq("bus_zero_idle", 32'(bad_zero), 32'd0);
    check_eq("sel_during", 32'(bad_sel), 32'd0);
    check_eq("cmd_ready_busy", 32'(bad_rdy), 32'd0);

    hold_data = rsp_data[idx];
    hold_err  = rsp_err[idx];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(rsp_valid[idx]), 32'd1);
      check_eq("stall_data", rsp_data[idx], hold_data);
      check_eq("stall_err", 32'(rsp_err[idx]), 32'(hold_err));
      check_eq("stall_cmd_ready", 32'(cmd_ready[idx]), 32'd0);
    end
    rsp_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid[idx]), 32'd0);
    check_eq("ready_after_hs", 32'(cmd_ready[idx]), 32'd1);

    if (!exp_err && wr && (op <= 3'd1)) begin
      if (dt) sb_d[idx][addr[5:2]] = wdata;
      else    sb_i[idx][addr[5:2]] = wdata;
    end
    m_sel[idx]  = exp_sel;
    m_held[idx] = exp_held;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          nrsp;
    int          r, idx;
    logic [2:0]  op;

    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0;  cmd_op[k] = '0;  cmd_addr[k] = '0;  cmd_wdata[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outs(0);
    check_reset_outs(1);

    // Refused read before any HOLD, then settle and a write.
    do_cmd(0, OP_RD_D, 32'h10, 32'h0, 0);
    do_cmd(0, OP_HOLD, 32'h0, 32'h0, 0);
    do_cmd(0, OP_WR_I, 32'h4, 32'hDEADBEEF, 0);
    do_cmd(0, OP_RD_I, 32'h4, 32'h0, 0);
    do_cmd(1, OP_HOLD, 32'h0, 32'h0, 0);
    do_cmd(1, OP_WR_I, 32'h4, 32'hDEADBEEF, 0);
    do_cmd(1, OP_RD_I, 32'h4, 32'h0, 0);

    // Long response stall, then back-to-back write and readback.
    do_cmd(0, OP_WR_D, 32'h8, 32'h1234_5678, 10);
    do_cmd(0, OP_RD_D, 32'h8, 32'h0, 0);
    do_cmd(0, OP_HOLD, 32'h0, 32'h0, 0);

    // Release refuses memory access; illegal ops always refused.
    do_cmd(0, OP_RELEASE, 32'h0, 32'h0, 0);
    do_cmd(0, OP_WR_D, 32'h8, 32'hCAFE_F00D, 0);
    do_cmd(0, 3'b110, 32'h0, 32'h0, 0);
    do_cmd(1, 3'b111, 32'h0, 32'h0, 1);

    for (int it = 0; it < 160; it++) begin
      idx = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 19));
      if (r < 12 || r > 15) op = 3'(r % 4);
      else if (r < 14)      op = OP_HOLD;
      else if (r == 14)     op = OP_RELEASE;
      else                  op = 3'($urandom_range(6, 7));
      do_cmd(idx, op, 32'($urandom_range(0, 15)) << 2, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while instance 1 waits on a 3-cycle read.
    if (!m_held[1]) do_cmd(1, OP_HOLD, 32'h0, 32'h0, 0);
    cmd_valid[1] = 1'b1;  cmd_op[1] = OP_RD_I;  cmd_addr[1] = 32'h4;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    check_eq("mid_rden", 32'(rden_i[1]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_outs(0);
    check_reset_outs(1);
    rsp_ready[1] = 1'b1;
    nrsp = 0;
    repeat (8) begin
      if (rsp_valid[1] === 1'b1) nrsp++;
      @(negedge clk);
    end
    rsp_ready[1] = 1'b0;
    check_eq("no_rsp_after_reset", 32'(nrsp), 32'd0);

    do_cmd(1, OP_RD_I, 32'h4, 32'h0, 0);
    do_cmd(1, OP_HOLD, 32'h0, 32'h0, 0);
    do_cmd(1, OP_WR_D, 32'h3C, 32'h0BAD_CAFE, 0);
    do_cmd(1, OP_RD_D, 32'h3C, 32'h0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
